// File: rtl/pci_mem_pkg.sv
// rtl/pci_mem_pkg.sv - shared constants for the PCI memory target front end
package pci_mem_pkg;

  // Default decoded window (log2 bytes) and the matching word-offset width
  localparam int WIN_BITS_DEF = 24;
  localparam int OFF_W_DEF    = WIN_BITS_DEF - 2;

  // Write-buffer entry fields: {offset, data, byte enables}
  localparam int DATA_W      = 32;
  localparam int BE_W        = 4;
  localparam int ENTRY_W_DEF = OFF_W_DEF + DATA_W + BE_W;

  // Target FSM encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RETRY  = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_WDRAIN = 3'd3;
  localparam logic [2:0] ST_RREQ   = 3'd4;
  localparam logic [2:0] ST_RDATA  = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count, show-ahead head
module sync_fifo #(
  parameter int WIDTH = 58,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only honoured when the head leaves the same cycle
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset empties the buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pci_mem_target.sv
// rtl/pci_mem_target.sv - PCI target burst to word-addressed DDR request bridge
module pci_mem_target
  import pci_mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int WIN_BITS   = WIN_BITS_DEF,
  parameter int RD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        base_hit,
  input  logic [31:0] addr,
  input  logic [31:0] adio_out,
  input  logic [3:0]  s_cbe,
  input  logic        s_wrdn,
  input  logic        s_data,
  input  logic        s_data_vld,
  output logic [31:0] adio_in,
  output logic        s_ready,
  output logic        s_term,
  output logic        s_abort,
  output logic [31:0] ddr_addr,
  output logic [31:0] ddr_wdata,
  output logic [3:0]  ddr_wbe,
  output logic        ddr_wr_valid,
  output logic        ddr_write,
  output logic        ddr_hit,
  output logic        ddr_hit_early,
  output logic        ddr_done,
  input  logic        ddr_not_ready,
  input  logic        ddr_wait,
  input  logic [31:0] ddr_rdata,
  input  logic        ddr_rdata_vld
);

  localparam int OFF_W = WIN_BITS - 2;
  localparam int ENT_W = OFF_W + DATA_W + BE_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TMO_W = $clog2(RD_TIMEOUT + 1);

  logic [2:0]        state;
  logic [OFF_W-1:0]  off;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              s_data_q;
  logic              s_data_fall;
  logic              wr_phase;
  logic              rd_phase;

  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_next;
  logic [ENT_W-1:0]  head;
  logic [OFF_W-1:0]  head_off;
  logic [DATA_W-1:0] head_data;
  logic [BE_W-1:0]   head_be;
  logic [OFF_W-1:0]  addr_word;
  logic              addr_unused;

  assign addr_unused = ^{addr[1:0], addr[31:WIN_BITS]};

  assign wr_phase    = (state == ST_WRITE) || (state == ST_WDRAIN);
  assign rd_phase    = (state == ST_RREQ)  || (state == ST_RDATA);
  assign s_data_fall = s_data_q && !s_data;

  // Write beats enter the buffer only while the burst is live; the head drains whenever DDR accepts
  assign push       = (state == ST_WRITE) && s_data_vld && (!fifo_full || pop);
  assign pop        = wr_phase && !fifo_empty && !ddr_wait;
  assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({off, adio_out, ~s_cbe}),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign {head_off, head_data, head_be} = head;

  // DDR side: write beats carry the buffered offset, reads carry the live offset
  assign addr_word     = pop ? head_off : (rd_phase ? off : '0);
  assign ddr_addr      = 32'({addr_word, 2'b00});
  assign ddr_wdata     = pop ? head_data : '0;
  assign ddr_wbe       = pop ? head_be : '0;
  assign ddr_wr_valid  = pop;
  assign ddr_write     = wr_phase;
  assign ddr_hit       = wr_phase || rd_phase;
  assign ddr_done      = (state == ST_DONE);
  assign s_abort       = 1'b0;

  // Delayed s_data for detecting the end of the data phases
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s_data_q <= 1'b0;
    else      s_data_q <= s_data;
  end

  // Target FSM with registered PCI handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      off           <= '0;
      tmo_cnt       <= '0;
      s_ready       <= 1'b0;
      s_term        <= 1'b0;
      adio_in       <= '0;
      ddr_hit_early <= 1'b0;
    end else begin
      ddr_hit_early <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (base_hit) begin
            if (ddr_not_ready) begin
              state   <= ST_RETRY;
              s_term  <= 1'b1;
              s_ready <= 1'b0;
            end else begin
              off           <= addr[WIN_BITS-1:2];
              tmo_cnt       <= '0;
              ddr_hit_early <= 1'b1;
              if (s_wrdn) begin
                state   <= ST_WRITE;
                s_ready <= 1'b1;
              end else begin
                state <= ST_RREQ;
              end
            end
          end
        end
        ST_RETRY: begin
          if (s_data_fall) begin
            state  <= ST_IDLE;
            s_term <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (push) off <= off + OFF_W'(1);
          // Keep two free slots so a beat already in flight can always land
          if (s_data_fall) begin
            state   <= ST_WDRAIN;
            s_ready <= 1'b0;
          end else begin
            s_ready <= (count_next <= CNT_W'(FIFO_DEPTH - 2));
          end
        end
        ST_WDRAIN: begin
          if (fifo_empty) state <= ST_DONE;
        end
        ST_RREQ: begin
          // Once disconnect is signalled, late read data is ignored
          if (s_data_fall) begin
            state   <= ST_DONE;
            s_ready <= 1'b0;
          end else if (!s_term) begin
            if (ddr_rdata_vld) begin
              adio_in <= ddr_rdata;
              s_ready <= 1'b1;
              tmo_cnt <= '0;
              state   <= ST_RDATA;
            end else if (tmo_cnt == TMO_W'(RD_TIMEOUT - 1)) begin
              s_term  <= 1'b1;
              s_ready <= 1'b0;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
        end
        ST_RDATA: begin
          if (s_data_fall) begin
            state   <= ST_DONE;
            s_ready <= 1'b0;
          end else if (s_data_vld) begin
            off     <= off + OFF_W'(1);
            s_ready <= 1'b0;
            state   <= ST_RREQ;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          s_term  <= 1'b0;
          s_ready <= 1'b0;
          tmo_cnt <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pci_mem_target.sv
// tb/tb_pci_mem_target.sv - directed scoreboard bench for pci_mem_target
module tb_pci_mem_target;

  logic        clk = 1'b0;
  logic        rst;
  logic        base_hit;
  logic [31:0] addr;
  logic [31:0] adio_out;
  logic [3:0]  s_cbe;
  logic        s_wrdn;
  logic        s_data;
  logic        s_data_vld;
  logic [31:0] adio_in;
  logic        s_ready;
  logic        s_term;
  logic        s_abort;
  logic [31:0] ddr_addr;
  logic [31:0] ddr_wdata;
  logic [3:0]  ddr_wbe;
  logic        ddr_wr_valid;
  logic        ddr_write;
  logic        ddr_hit;
  logic        ddr_hit_early;
  logic        ddr_done;
  logic        ddr_not_ready;
  logic        ddr_wait;
  logic [31:0] ddr_rdata;
  logic        ddr_rdata_vld;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  bit          hit_seen = 1'b0;
  logic [21:0] cur_off;
  logic [67:0] wq[$];
  logic [31:0] rq[$];

  always #5 clk = ~clk;

  pci_mem_target dut (
    .clk           (clk),
    .rst           (rst),
    .base_hit      (base_hit),
    .addr          (addr),
    .adio_out      (adio_out),
    .s_cbe         (s_cbe),
    .s_wrdn        (s_wrdn),
    .s_data        (s_data),
    .s_data_vld    (s_data_vld),
    .adio_in       (adio_in),
    .s_ready       (s_ready),
    .s_term        (s_term),
    .s_abort       (s_abort),
    .ddr_addr      (ddr_addr),
    .ddr_wdata     (ddr_wdata),
    .ddr_wbe       (ddr_wbe),
    .ddr_wr_valid  (ddr_wr_valid),
    .ddr_write     (ddr_write),
    .ddr_hit       (ddr_hit),
    .ddr_hit_early (ddr_hit_early),
    .ddr_done      (ddr_done),
    .ddr_not_ready (ddr_not_ready),
    .ddr_wait      (ddr_wait),
    .ddr_rdata     (ddr_rdata),
    .ddr_rdata_vld (ddr_rdata_vld)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_txn(input logic [31:0] a, input logic wr);
    base_hit = 1'b1;
    addr     = a;
    s_wrdn   = wr;
    s_data   = 1'b1;
    cur_off  = a[23:2];
    step();
    base_hit = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    for (int g = 0; g < 64 && !s_ready; g++) step();
    chk1(tag, s_ready, 1'b1);
  endtask

  task automatic wr_beat(input logic [31:0] d, input logic [3:0] cbe);
    wq.push_back({8'b0, cur_off, 2'b00, d, ~cbe});
    adio_out   = d;
    s_cbe      = cbe;
    s_data_vld = 1'b1;
    step();
    s_data_vld = 1'b0;
    s_cbe      = 4'hF;
    cur_off    = cur_off + 22'd1;
  endtask

  task automatic finish_txn(input string tag);
    int d0;
    d0     = done_cnt;
    s_data = 1'b0;
    for (int g = 0; g < 64 && done_cnt == d0; g++) step();
    chk({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    step();
    step();
    chk({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    chk1({tag, "_hit_clr"}, ddr_hit, 1'b0);
    chk({tag, "_wq_empty"}, 32'(wq.size()), 32'd0);
  endtask

  // DDR-side monitor: every write beat is checked against the scoreboard
  always @(negedge clk) begin
    logic [67:0] e;
    if (ddr_done) done_cnt++;
    if (ddr_hit || ddr_hit_early) hit_seen = 1'b1;
    if (ddr_wr_valid) begin
      chk1("wr_pending", ddr_wr_valid, wq.size() != 0);
      if (wq.size() != 0) begin
        e = wq.pop_front();
        chk("wr_addr", ddr_addr, e[67:36]);
        chk("wr_data", ddr_wdata, e[35:4]);
        chk("wr_be", {28'b0, ddr_wbe}, {28'b0, e[3:0]});
        chk1("wr_write", ddr_write, 1'b1);
      end
    end
  end

  initial begin
    int n;
    int k;
    rst           = 1'b0;
    base_hit      = 1'b0;
    addr          = '0;
    adio_out      = '0;
    s_cbe         = 4'hF;
    s_wrdn        = 1'b0;
    s_data        = 1'b0;
    s_data_vld    = 1'b0;
    ddr_not_ready = 1'b0;
    ddr_wait      = 1'b0;
    ddr_rdata     = '0;
    ddr_rdata_vld = 1'b0;
    cur_off       = '0;
    repeat (3) step();

    chk1("rst_ready", s_ready, 1'b0);
    chk1("rst_term", s_term, 1'b0);
    chk1("rst_abort", s_abort, 1'b0);
    chk1("rst_hit", ddr_hit, 1'b0);
    chk1("rst_hit_early", ddr_hit_early, 1'b0);
    chk1("rst_done", ddr_done, 1'b0);
    chk1("rst_wr_valid", ddr_wr_valid, 1'b0);
    chk("rst_addr", ddr_addr, 32'h0);
    chk("rst_adio", adio_in, 32'h0);
    rst = 1'b1;
    step();

    // DDR not ready: retry, no DDR activity
    ddr_not_ready = 1'b1;
    start_txn(32'h0000_0100, 1'b1);
    chk1("retry_term", s_term, 1'b1);
    chk1("retry_ready", s_ready, 1'b0);
    repeat (3) step();
    chk1("retry_term_hold", s_term, 1'b1);
    s_data = 1'b0;
    step();
    chk1("retry_term_clr", s_term, 1'b0);
    step();
    chk1("retry_no_hit", hit_seen, 1'b0);
    ddr_not_ready = 1'b0;

    // Write burst of 4, no DDR backpressure, with an ignored base_hit mid-burst
    start_txn(32'h0000_0100, 1'b1);
    chk1("w4_hit_early", ddr_hit_early, 1'b1);
    chk1("w4_hit", ddr_hit, 1'b1);
    chk1("w4_ready0", s_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_ready("w4_ready");
      wr_beat(32'h11 * (i + 1), 4'h0);
      if (i == 1) begin
        base_hit = 1'b1;
        s_wrdn   = 1'b0;
        addr     = 32'h0000_0500;
        step();
        base_hit = 1'b0;
        s_wrdn   = 1'b1;
        chk1("w4_rehit_ignored", ddr_hit_early, 1'b0);
        chk1("w4_still_write", ddr_write, 1'b1);
      end
    end
    chk1("w4_hit_early_pulse", ddr_hit_early, 1'b0);
    finish_txn("w4");

    // Write burst of 12 while DDR stalls: ready must drop before overrun
    ddr_wait = 1'b1;
    start_txn(32'h0000_0200, 1'b1);
    n = 0;
    while (n < 12 && s_ready) begin
      wr_beat(32'h1000 + 32'(n), 4'(n));
      n++;
    end
    chk("w12_stall_beats", 32'(n), 32'd7);
    chk1("w12_ready_low", s_ready, 1'b0);
    repeat (3) step();
    chk1("w12_ready_hold", s_ready, 1'b0);
    chk("w12_no_pop", 32'(wq.size()), 32'd7);
    ddr_wait = 1'b0;
    while (n < 12) begin
      wait_ready("w12_ready");
      wr_beat(32'h1000 + 32'(n), 4'(n));
      n++;
    end
    finish_txn("w12");

    // Read burst of 3 at 0x20, data 4 clocks after each request
    start_txn(32'h0000_0020, 1'b0);
    chk1("rd_write_low", ddr_write, 1'b0);
    chk1("rd_hit", ddr_hit, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("rd_addr", ddr_addr, 32'h20 + 32'(4 * i));
      chk1("rd_wait_ready", s_ready, 1'b0);
      repeat (3) step();
      ddr_rdata     = 32'hC0DE_0000 + 32'(i);
      ddr_rdata_vld = 1'b1;
      rq.push_back(ddr_rdata);
      step();
      ddr_rdata_vld = 1'b0;
      ddr_rdata     = '0;
      chk1("rd_ready", s_ready, 1'b1);
      chk("rd_data", adio_in, rq.pop_front());
      s_data_vld = 1'b1;
      step();
      s_data_vld = 1'b0;
      chk1("rd_ready_clr", s_ready, 1'b0);
    end
    finish_txn("rd3");

    // Read timeout: disconnect on the 16th clock, late data discarded
    start_txn(32'h0000_0040, 1'b0);
    for (k = 1; k <= 40; k++) begin
      step();
      if (s_term) break;
    end
    chk("tmo_clock", 32'(k), 32'd16);
    chk1("tmo_ready", s_ready, 1'b0);
    ddr_rdata     = 32'hDEAD_BEEF;
    ddr_rdata_vld = 1'b1;
    step();
    ddr_rdata_vld = 1'b0;
    chk("tmo_late_data", adio_in, 32'hC0DE_0002);
    chk1("tmo_late_ready", s_ready, 1'b0);
    finish_txn("tmo");
    chk1("tmo_term_clr", s_term, 1'b0);
    ddr_rdata_vld = 1'b1;
    step();
    ddr_rdata_vld = 1'b0;
    chk("idle_late_data", adio_in, 32'hC0DE_0002);
    chk1("idle_late_ready", s_ready, 1'b0);

    // Offset wrap at the top of the window; upper address bits are dropped
    start_txn(32'hABFF_FFFC, 1'b1);
    chk("wrap_first_off", {10'b0, cur_off}, 32'h003F_FFFF);
    wait_ready("wrap_ready");
    wr_beat(32'hCAFE_0001, 4'b1010);
    wait_ready("wrap_ready");
    wr_beat(32'hCAFE_0002, 4'b0101);
    finish_txn("wrap");

    // Reset in the middle of a stalled write: buffer discarded, no done
    ddr_wait = 1'b1;
    start_txn(32'h0000_0300, 1'b1);
    for (int i = 0; i < 3; i++) wr_beat(32'h5000 + 32'(i), 4'h0);
    k   = done_cnt;
    rst = 1'b0;
    wq.delete();
    step();
    chk1("mid_rst_hit", ddr_hit, 1'b0);
    chk1("mid_rst_ready", s_ready, 1'b0);
    chk1("mid_rst_wr_valid", ddr_wr_valid, 1'b0);
    s_data   = 1'b0;
    ddr_wait = 1'b0;
    step();
    rst = 1'b1;
    repeat (4) step();
    chk("mid_rst_no_done", 32'(done_cnt - k), 32'd0);
    chk1("mid_rst_idle_wr", ddr_wr_valid, 1'b0);
    chk("mid_rst_addr", ddr_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
